// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the elastic pipeline stage register.
// Holds the MEM/WB bundle layout and the legal chaining depth limit.
package pipe_pkg;

   // Default payload: the MEM/WB bundle.
   localparam int ALU_W   = 32;
   localparam int RDATA_W = 32;
   localparam int RD_W    = 5;
   localparam int PC4_W   = 32;

   localparam int MEMWB_W = ALU_W + RDATA_W + RD_W + PC4_W;

   // Field offsets inside a packed MEM/WB payload word (LSB first).
   localparam int ALU_LSB   = 0;
   localparam int RDATA_LSB = ALU_LSB + ALU_W;
   localparam int RD_LSB    = RDATA_LSB + RDATA_W;
   localparam int PC4_LSB   = RD_LSB + RD_W;

   localparam int DEPTH_MAX = 4;

   // Same layout as the offsets above; the last member sits at bit 0.
   typedef struct packed {
      logic [PC4_W-1:0]   pc_plus4;
      logic [RD_W-1:0]    rd;
      logic [RDATA_W-1:0] read_data;
      logic [ALU_W-1:0]   alu_result;
   } memwb_t;

   function automatic logic [MEMWB_W-1:0] pack_memwb(
      input logic [ALU_W-1:0]   alu_result,
      input logic [RDATA_W-1:0] read_data,
      input logic [RD_W-1:0]    rd,
      input logic [PC4_W-1:0]   pc_plus4
   );
      memwb_t b;
      b.alu_result = alu_result;
      b.read_data  = read_data;
      b.rd         = rd;
      b.pc_plus4   = pc_plus4;
      return b;
   endfunction

   function automatic memwb_t unpack_memwb(
      input logic [MEMWB_W-1:0] word
   );
      return memwb_t'(word);
   endfunction

endpackage

// File: rtl/pipe_stage_reg_slot.sv
// pipe_skid_slot: one two-entry skid slot (main + skid register).
// Ports: clk, reset, flush; up_valid/up_data/up_ready from the
// producer; dn_valid/dn_data/dn_ready to the consumer; had_valid is
// high while the slot holds any entry (main or skid).
module pipe_skid_slot
   import pipe_pkg::*;
#(
   parameter int WIDTH = MEMWB_W
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             up_valid,
   input  logic [WIDTH-1:0] up_data,
   output logic             up_ready,
   output logic             dn_valid,
   output logic [WIDTH-1:0] dn_data,
   input  logic             dn_ready,
   output logic             had_valid
);

   logic             mv_q, mv_d;
   logic             sv_q, sv_d;
   logic [WIDTH-1:0] md_q, md_d;
   logic [WIDTH-1:0] sd_q, sd_d;
   logic             xfer_in;

   // Ready comes straight from a flop, so there is no combinational
   // path from dn_ready back to up_ready.
   assign up_ready  = !sv_q;
   assign dn_valid  = mv_q;
   assign dn_data   = md_q;
   assign had_valid = mv_q | sv_q;

   always_comb begin
      xfer_in = up_valid && !sv_q;
      mv_d    = mv_q;
      sv_d    = sv_q;
      md_d    = md_q;
      sd_d    = sd_q;
      if (flush) begin
         // Data registers keep their contents; only valids die.
         mv_d = 1'b0;
         sv_d = 1'b0;
      end else if (!mv_q || dn_ready) begin
         // Main is free (or drains this edge): refill from the skid
         // first so ordering holds; the producer is stalled while
         // the skid is full, so both cannot happen together.
         if (sv_q) begin
            md_d = sd_q;
            mv_d = 1'b1;
            sv_d = 1'b0;
         end else begin
            mv_d = xfer_in;
            if (xfer_in) begin
               md_d = up_data;
            end
         end
      end else if (xfer_in) begin
         // Main is stalled: park the late arrival in the skid.
         sd_d = up_data;
         sv_d = 1'b1;
      end
   end

   // State moves on the falling edge, like the other pipeline regs.
   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         mv_q <= 1'b0;
         sv_q <= 1'b0;
         md_q <= '0;
         sd_q <= '0;
      end else begin
         mv_q <= mv_d;
         sv_q <= sv_d;
         md_q <= md_d;
         sd_q <= sd_d;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: DEPTH chained skid slots with flush and drop count.
// Ports: clk, reset, flush; in_valid/in_data/in_ready upstream;
// out_valid/out_data/out_ready downstream; drop_cnt (saturating).
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int WIDTH = MEMWB_W,
   parameter int DEPTH = 1,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [CNT_W-1:0] drop_cnt
);

   // Out-of-range depths are pinned to the legal 1..DEPTH_MAX window.
   localparam int D = (DEPTH < 1) ? 1 :
                      ((DEPTH > DEPTH_MAX) ? DEPTH_MAX : DEPTH);

   logic [D-1:0]     up_r;
   logic [D-1:0]     dn_v;
   logic [WIDTH-1:0] dn_d [D];
   logic [D-1:0]     had;

   for (genvar k = 0; k < D; k++) begin : g_slot
      logic             up_v;
      logic [WIDTH-1:0] up_d;
      logic             dn_r;

      if (k == 0) begin : g_head
         assign up_v = in_valid;
         assign up_d = in_data;
      end else begin : g_body
         assign up_v = dn_v[k-1];
         assign up_d = dn_d[k-1];
      end

      if (k == D - 1) begin : g_tail
         assign dn_r = out_ready;
      end else begin : g_link
         assign dn_r = up_r[k+1];
      end

      pipe_skid_slot #(
         .WIDTH (WIDTH)
      ) u_slot (
         .clk       (clk),
         .reset     (reset),
         .flush     (flush),
         .up_valid  (up_v),
         .up_data   (up_d),
         .up_ready  (up_r[k]),
         .dn_valid  (dn_v[k]),
         .dn_data   (dn_d[k]),
         .dn_ready  (dn_r),
         .had_valid (had[k])
      );
   end

   assign in_ready  = up_r[0];
   assign out_valid = dn_v[D-1];
   assign out_data  = dn_d[D-1];

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             cnt_max;

   assign cnt_max  = (cnt_q == {CNT_W{1'b1}});
   assign drop_cnt = cnt_q;

   // One count per flush that actually killed something.
   always_comb begin
      cnt_d = cnt_q;
      if (flush && (|had) && !cnt_max) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed and randomized checks for pipe_stage_reg.
// Three instances: DEPTH=2/CNT_W=2, DEPTH=1, DEPTH=4.
module tb_pipe_stage_reg;

   localparam int W = 16;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic flush = 1'b0;

   logic         a_in_valid = 1'b0;
   logic [W-1:0] a_in_data = '0;
   logic         a_in_ready;
   logic         a_out_valid;
   logic [W-1:0] a_out_data;
   logic         a_out_ready = 1'b0;
   logic [1:0]   a_drop;

   logic         b_in_valid = 1'b0;
   logic [W-1:0] b_in_data = '0;
   logic         b_in_ready;
   logic         b_out_valid;
   logic [W-1:0] b_out_data;
   logic         b_out_ready = 1'b0;
   logic [15:0]  b_drop;

   logic         c_in_valid = 1'b0;
   logic [W-1:0] c_in_data = '0;
   logic         c_in_ready;
   logic         c_out_valid;
   logic [W-1:0] c_out_data;
   logic         c_out_ready = 1'b0;
   logic [15:0]  c_drop;

   int cmp_n = 0;
   int err_n = 0;

   always #5 clk = ~clk;

   pipe_stage_reg #(.WIDTH(W), .DEPTH(2), .CNT_W(2)) u_a (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(a_in_valid), .in_data(a_in_data),
      .in_ready(a_in_ready), .out_valid(a_out_valid),
      .out_data(a_out_data), .out_ready(a_out_ready),
      .drop_cnt(a_drop)
   );

   pipe_stage_reg #(.WIDTH(W), .DEPTH(1), .CNT_W(16)) u_b (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(b_in_valid), .in_data(b_in_data),
      .in_ready(b_in_ready), .out_valid(b_out_valid),
      .out_data(b_out_data), .out_ready(b_out_ready),
      .drop_cnt(b_drop)
   );

   pipe_stage_reg #(.WIDTH(W), .DEPTH(4), .CNT_W(16)) u_c (
      .clk(clk), .reset(reset), .flush(flush),
      .in_valid(c_in_valid), .in_data(c_in_data),
      .in_ready(c_in_ready), .out_valid(c_out_valid),
      .out_data(c_out_data), .out_ready(c_out_ready),
      .drop_cnt(c_drop)
   );

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic idle();
      flush = 1'b0;
      a_in_valid = 1'b0; a_out_ready = 1'b0;
      b_in_valid = 1'b0; b_out_ready = 1'b0;
      c_in_valid = 1'b0; c_out_ready = 1'b0;
   endtask

   task automatic do_reset();
      idle();
      reset = 1'b1;
      #2;
      reset = 1'b0;
      tick();
   endtask

   task automatic test_reset();
      logic seen;
      #2;
      cmp_n++; if (a_out_valid !== 1'b0) begin err_n++;
         $display("FAIL por_out_valid: got %b want 0", a_out_valid); end
      cmp_n++; if (a_in_ready !== 1'b1) begin err_n++;
         $display("FAIL por_in_ready: got %b want 1", a_in_ready); end
      #2;
      reset = 1'b0;
      a_in_valid = 1'b1; a_in_data = 16'h0001;
      tick();
      a_in_data = 16'h0002;
      tick();
      a_in_data = 16'h0003;
      tick();
      a_in_valid = 1'b0;
      cmp_n++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0001) begin
         err_n++;
         $display("FAIL rst_preload: got v=%b d=%h want v=1 d=0001",
                  a_out_valid, a_out_data); end
      #2;
      reset = 1'b1;
      #1;
      cmp_n++; if (a_out_valid !== 1'b0) begin err_n++;
         $display("FAIL rst_out_valid: got %b want 0", a_out_valid); end
      cmp_n++; if (a_out_data !== 16'h0000) begin err_n++;
         $display("FAIL rst_out_data: got %h want 0000", a_out_data); end
      cmp_n++; if (a_in_ready !== 1'b1) begin err_n++;
         $display("FAIL rst_in_ready: got %b want 1", a_in_ready); end
      cmp_n++; if (a_drop !== 2'd0) begin err_n++;
         $display("FAIL rst_drop: got %0d want 0", a_drop); end
      #1;
      reset = 1'b0;
      a_out_ready = 1'b1;
      seen = 1'b0;
      repeat (6) begin
         tick();
         if (a_out_valid) seen = 1'b1;
      end
      cmp_n++; if (seen !== 1'b0) begin err_n++;
         $display("FAIL rst_no_emit: got %b want 0", seen); end
   endtask

   task automatic test_stream();
      do_reset();
      a_out_ready = 1'b1;
      a_in_valid = 1'b1; a_in_data = 16'h0001;
      tick();
      cmp_n++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         err_n++;
         $display("FAIL str_lat0: got v=%b r=%b want v=0 r=1",
                  a_out_valid, a_in_ready); end
      a_in_data = 16'h0002;
      tick();
      cmp_n++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0001) begin
         err_n++;
         $display("FAIL str_d1: got v=%b d=%h want v=1 d=0001",
                  a_out_valid, a_out_data); end
      a_in_data = 16'h0003;
      tick();
      cmp_n++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0002) begin
         err_n++;
         $display("FAIL str_d2: got v=%b d=%h want v=1 d=0002",
                  a_out_valid, a_out_data); end
      a_in_valid = 1'b0;
      tick();
      cmp_n++; if (a_out_valid !== 1'b1 || a_out_data !== 16'h0003) begin
         err_n++;
         $display("FAIL str_d3: got v=%b d=%h want v=1 d=0003",
                  a_out_valid, a_out_data); end
      tick();
      cmp_n++; if (a_out_valid !== 1'b0 || a_out_data !== 16'h0003) begin
         err_n++;
         $display("FAIL str_empty: got v=%b d=%h want v=0 d=0003",
                  a_out_valid, a_out_data); end
   endtask

   task automatic test_backpressure();
      do_reset();
      b_out_ready = 1'b0;
      b_in_valid = 1'b1; b_in_data = 16'h000A;
      tick();
      cmp_n++; if (b_in_ready !== 1'b1 || b_out_data !== 16'h000A) begin
         err_n++;
         $display("FAIL bp_a: got r=%b d=%h want r=1 d=000a",
                  b_in_ready, b_out_data); end
      b_in_data = 16'h000B;
      tick();
      cmp_n++; if (b_in_ready !== 1'b0) begin err_n++;
         $display("FAIL bp_full: got r=%b want 0", b_in_ready); end
      b_in_data = 16'h000C;
      tick();
      cmp_n++; if (b_in_ready !== 1'b0 || b_out_data !== 16'h000A) begin
         err_n++;
         $display("FAIL bp_hold: got r=%b d=%h want r=0 d=000a",
                  b_in_ready, b_out_data); end
      b_out_ready = 1'b1;
      tick();
      cmp_n++; if (b_out_data !== 16'h000B || b_in_ready !== 1'b1) begin
         err_n++;
         $display("FAIL bp_b: got d=%h r=%b want d=000b r=1",
                  b_out_data, b_in_ready); end
      tick();
      b_in_valid = 1'b0;
      cmp_n++; if (b_out_valid !== 1'b1 || b_out_data !== 16'h000C) begin
         err_n++;
         $display("FAIL bp_c: got v=%b d=%h want v=1 d=000c",
                  b_out_valid, b_out_data); end
      tick();
      cmp_n++; if (b_out_valid !== 1'b0 || b_out_data !== 16'h000C) begin
         err_n++;
         $display("FAIL bp_drain: got v=%b d=%h want v=0 d=000c",
                  b_out_valid, b_out_data); end
   endtask

   task automatic test_flush();
      logic seen;
      do_reset();
      a_out_ready = 1'b0;
      a_in_valid = 1'b1; a_in_data = 16'h0011;
      tick();
      a_in_data = 16'h0022;
      tick();
      a_in_data = 16'h0055;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      a_in_valid = 1'b0;
      cmp_n++; if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
         err_n++;
         $display("FAIL fl_clear: got v=%b r=%b want v=0 r=1",
                  a_out_valid, a_in_ready); end
      cmp_n++; if (a_drop !== 2'd1) begin err_n++;
         $display("FAIL fl_drop: got %0d want 1", a_drop); end
      a_out_ready = 1'b1;
      seen = 1'b0;
      repeat (4) begin
         tick();
         if (a_out_valid) seen = 1'b1;
      end
      cmp_n++; if (seen !== 1'b0) begin err_n++;
         $display("FAIL fl_no_emit: got %b want 0", seen); end
      flush = 1'b1;
      tick();
      flush = 1'b0;
      cmp_n++; if (a_drop !== 2'd1) begin err_n++;
         $display("FAIL fl_empty: got %0d want 1", a_drop); end
   endtask

   task automatic test_saturation();
      logic [1:0] exp;
      do_reset();
      a_out_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         a_in_valid = 1'b1;
         a_in_data = 16'(i + 16'h0100);
         tick();
         a_in_valid = 1'b0;
         flush = 1'b1;
         tick();
         flush = 1'b0;
         exp = (i >= 2) ? 2'd3 : 2'(i + 1);
         cmp_n++; if (a_drop !== exp) begin err_n++;
            $display("FAIL sat_%0d: got %0d want %0d", i, a_drop, exp); end
      end
   endtask

   task automatic test_random();
      logic [W-1:0] q[$];
      logic [W-1:0] exp;
      logic ir;
      do_reset();
      for (int n = 0; n < 3020; n++) begin
         if (n < 3000) begin
            c_in_valid = ($urandom_range(0, 3) != 0);
            c_in_data = 16'($urandom);
            if (n < 1500) c_out_ready = ($urandom_range(0, 1) == 1);
            else c_out_ready = ($urandom_range(0, 3) != 0);
         end else begin
            c_in_valid = 1'b0;
            c_out_ready = 1'b1;
         end
         @(posedge clk);
         if (c_out_valid && c_out_ready) begin
            cmp_n++;
            if (q.size() == 0) begin
               err_n++;
               $display("FAIL rnd_extra: got %h want nothing", c_out_data);
            end else begin
               exp = q.pop_front();
               if (c_out_data !== exp) begin err_n++;
                  $display("FAIL rnd_data: got %h want %h",
                           c_out_data, exp); end
            end
         end
         if (c_in_valid && c_in_ready) q.push_back(c_in_data);
         ir = c_in_ready;
         c_out_ready = !c_out_ready;
         #1;
         cmp_n++; if (c_in_ready !== ir) begin err_n++;
            $display("FAIL rnd_comb_ready: got %b want %b",
                     c_in_ready, ir); end
         c_out_ready = !c_out_ready;
         tick();
      end
      cmp_n++; if (q.size() != 0) begin err_n++;
         $display("FAIL rnd_lost: got %0d left want 0", q.size()); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_saturation();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***",
               cmp_n, err_n);
      $finish;
   end

endmodule
